// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the program/data RAM port arbiter.
// Requester ids, default widths and the grant selection helper.
package mem_port_arbiter_pkg;

   localparam int AW_DEF = 16;
   localparam int DW_DEF = 16;

   localparam logic REQ_CORE   = 1'b0;
   localparam logic REQ_LOADER = 1'b1;

   typedef struct packed {
      logic valid;
      logic id;
   } rd_tag_t;

   // Returns {m1_gnt, m0_gnt}; last_gnt is the id granted most recently.
   function automatic logic [1:0] arb_pick(input logic req0, input logic req1,
                                           input logic last_gnt, input logic rr_en);
      logic [1:0] g;
      g = 2'b00;
      if (req0 && req1) begin
         g = (rr_en && (last_gnt == REQ_CORE)) ? 2'b10 : 2'b01;
      end else if (req0) begin
         g = 2'b01;
      end else if (req1) begin
         g = 2'b10;
      end
      return g;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of both requester ports and the RAM command/data port.
// slave = arbiter view, master = requesters plus RAM view.
interface mem_port_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 16
);
   logic          m0_req;
   logic          m0_we;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata;
   logic          m0_gnt;
   logic          m0_rvalid;
   logic [DW-1:0] m0_rdata;

   logic          m1_req;
   logic          m1_we;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata;
   logic          m1_gnt;
   logic          m1_rvalid;
   logic [DW-1:0] m1_rdata;

   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_data;
   logic          mem_wren;
   logic [DW-1:0] mem_q;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      input  mem_q,
      output m0_gnt, m0_rvalid, m0_rdata,
      output m1_gnt, m1_rvalid, m1_rdata,
      output mem_address, mem_data, mem_wren
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      output mem_q,
      input  m0_gnt, m0_rvalid, m0_rdata,
      input  m1_gnt, m1_rvalid, m1_rdata,
      input  mem_address, mem_data, mem_wren
   );
endinterface

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// Shift register of {valid,id} tags, RD_LAT deep, that lines up each
// issued read with the cycle its data appears on mem_q.
module mem_port_arbiter_rd_tag_pipe
   import mem_port_arbiter_pkg::*;
#(
   parameter int RD_LAT = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic issue_valid,
   input  logic issue_id,
   output logic ret_valid,
   output logic ret_id
);

   rd_tag_t [RD_LAT-1:0] tag_q;
   rd_tag_t [RD_LAT-1:0] tag_d;

   always_comb begin
      tag_d          = tag_q;
      tag_d[0].valid = issue_valid;
      tag_d[0].id    = issue_id;
      for (int i = 1; i < RD_LAT; i++) begin
         tag_d[i] = tag_q[i-1];
      end
   end

   // Clearing the tags on reset is what discards in-flight reads.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_q <= '0;
      end else begin
         tag_q <= tag_d;
      end
   end

   assign ret_valid = tag_q[RD_LAT-1].valid;
   assign ret_id    = tag_q[RD_LAT-1].id;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single-port synchronous RAM: combinational
// grant, registered RAM command, read data routed back by id after RD_LAT.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW     = AW_DEF,
   parameter int DW     = DW_DEF,
   parameter int RD_LAT = 2,
   parameter int RR     = 1
) (
   input  logic                clk,
   input  logic                reset,
   mem_port_arbiter_if.slave   bus
);

   logic [1:0]    gnt;
   logic          last_gnt_q, last_gnt_d;
   logic [AW-1:0] mem_address_q, mem_address_d;
   logic [DW-1:0] mem_data_q, mem_data_d;
   logic          mem_wren_q, mem_wren_d;
   logic          issue_valid;
   logic          issue_id;
   logic          ret_valid;
   logic          ret_id;

   always_comb begin
      gnt           = arb_pick(bus.m0_req, bus.m1_req, last_gnt_q, RR != 0);
      last_gnt_d    = last_gnt_q;
      mem_address_d = mem_address_q;
      mem_data_d    = mem_data_q;
      mem_wren_d    = 1'b0;
      issue_valid   = 1'b0;
      issue_id      = REQ_CORE;
      if (gnt[0]) begin
         last_gnt_d    = REQ_CORE;
         mem_address_d = bus.m0_addr;
         mem_data_d    = bus.m0_wdata;
         mem_wren_d    = bus.m0_we;
         issue_valid   = ~bus.m0_we;
         issue_id      = REQ_CORE;
      end else if (gnt[1]) begin
         last_gnt_d    = REQ_LOADER;
         mem_address_d = bus.m1_addr;
         mem_data_d    = bus.m1_wdata;
         mem_wren_d    = bus.m1_we;
         issue_valid   = ~bus.m1_we;
         issue_id      = REQ_LOADER;
      end
   end

   // last_gnt resets to the loader so the core wins the first tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_gnt_q    <= REQ_LOADER;
         mem_address_q <= '0;
         mem_data_q    <= '0;
         mem_wren_q    <= 1'b0;
      end else begin
         last_gnt_q    <= last_gnt_d;
         mem_address_q <= mem_address_d;
         mem_data_q    <= mem_data_d;
         mem_wren_q    <= mem_wren_d;
      end
   end

   mem_port_arbiter_rd_tag_pipe #(
      .RD_LAT (RD_LAT)
   ) u_rd_tag_pipe (
      .clk         (clk),
      .reset       (reset),
      .issue_valid (issue_valid),
      .issue_id    (issue_id),
      .ret_valid   (ret_valid),
      .ret_id      (ret_id)
   );

   assign bus.m0_gnt      = gnt[0];
   assign bus.m1_gnt      = gnt[1];
   assign bus.m0_rvalid   = ret_valid & (ret_id == REQ_CORE);
   assign bus.m1_rvalid   = ret_valid & (ret_id == REQ_LOADER);
   assign bus.m0_rdata    = bus.mem_q;
   assign bus.m1_rdata    = bus.mem_q;
   assign bus.mem_address = mem_address_q;
   assign bus.mem_data    = mem_data_q;
   assign bus.mem_wren    = mem_wren_q;

endmodule
